// File: rtl/sample_stream_controller.sv
// sample_stream_controller: Pi serial deserialiser feeding a circular sample
// buffer that is drained one word per I2S ready request. Refill requests to the
// Pi are scheduled through rpi_interrupt using hysteretic watermarks.
`timescale 1ns/1ps
module sample_stream_controller #(
    parameter int DEPTH       = 64,
    parameter int LOW_WATER   = 16,
    parameter int HIGH_WATER  = 48,
    parameter int START_LEVEL = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         rpi_clk,
    input  logic                         serial,
    input  logic                         ready,
    output logic                         rpi_interrupt,
    output logic [15:0]                  data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         underrun,
    output logic                         overflow,
    output logic [$clog2(DEPTH)+3:0]     debug
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] LOW_C   = CW'(LOW_WATER);
    localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_WATER);
    localparam logic [CW-1:0] START_C = CW'(START_LEVEL);

    typedef enum logic [1:0] {PRIME = 2'd0, RUN = 2'd1} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic            wr_pend_q, wr_pend_d;
    logic [15:0]     data_q, data_d;
    logic            unr_q, unr_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [2:0]      rpi_q;     // [1:0] synchroniser, [2] edge history
    logic [2:0]      ser_q;     // serial delayed to line up with edge_q
    logic            edge_q;
    logic            ready_q;
    logic            req, do_wr, do_rd;
    logic [15:0]     mem_q [DEPTH];

    assign req = ready & ~ready_q;

    // Input conditioning: rpi_clk synchroniser + edge pulse, serial delay line, ready history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpi_q   <= '0;
            ser_q   <= '0;
            edge_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            rpi_q   <= {rpi_q[1:0], rpi_clk};
            ser_q   <= {ser_q[1:0], serial};
            edge_q  <= rpi_q[1] & ~rpi_q[2];
            ready_q <= ready;
        end
    end

    // Next-state: deserialiser, buffer bookkeeping, read sequencing and watermarks
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_pend_d = 1'b0;
        data_d    = data_q;
        unr_d     = unr_q;
        ovf_d     = ovf_q;
        irq_d     = irq_q;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        if (!enable) begin
            state_d   = PRIME;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
            data_d    = '0;
            unr_d     = 1'b0;
            ovf_d     = 1'b0;
            irq_d     = 1'b0;
        end else begin
            if (edge_q) begin
                shift_d[bit_cnt_q] = ser_q[2];
                bit_cnt_d          = bit_cnt_q + 4'd1;
                wr_pend_d          = (bit_cnt_q == 4'd15);
            end
            if (wr_pend_q) begin
                if (count_q == FULL_C) begin
                    ovf_d = 1'b1;
                end else begin
                    do_wr    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            case (state_q)
                PRIME: begin
                    data_d = '0;
                    if (count_q >= START_C) state_d = RUN;
                end
                RUN: begin
                    if (req) begin
                        // occupancy is judged before this cycle's write lands
                        if (count_q != '0) begin
                            do_rd    = 1'b1;
                            data_d   = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end else begin
                            data_d  = '0;
                            unr_d   = 1'b1;
                            state_d = PRIME;
                        end
                    end
                end
                default: state_d = PRIME;
            endcase
            count_d = count_q + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_rd};
            if (state_q == PRIME && count_q < START_C) irq_d = 1'b1;
            else if (count_q <= LOW_C)                 irq_d = 1'b1;
            else if (count_q >= HIGH_C)                irq_d = 1'b0;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PRIME;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wr_pend_q <= 1'b0;
            data_q    <= '0;
            unr_q     <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_pend_q <= wr_pend_d;
            data_q    <= data_d;
            unr_q     <= unr_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    // Sample RAM write port; contents need no reset
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rpi_interrupt = irq_q;
    assign data          = data_q;
    assign level         = count_q;
    assign underrun      = unr_q;
    assign overflow      = ovf_q;
    assign debug         = {state_q, count_q, bit_cnt_q[3]};
endmodule

// File: doc/sample_stream_controller.md
Name: sample_stream_controller

Overview:
- Single-clock controller that sequences the Pi-to-I2S sample path.
- Deserialises the Pi's shift stream into 16-bit words and queues them in a 64-entry circular buffer.
- Releases one word per I2S `ready` request.
- Schedules Pi refills through `rpi_interrupt` using low/high watermarks with hysteresis.
- Sits between the Pi serial link and the I2S transmitter, replacing the free-running dual-clock pointer logic with one synchronous controller.

Parameters:
- DEPTH, 64, buffer entries; power of two.
- LOW_WATER, 16, `rpi_interrupt` asserts when count <= LOW_WATER.
- HIGH_WATER, 48, `rpi_interrupt` deasserts when count >= HIGH_WATER.
- START_LEVEL, 32, count needed to leave PRIME.

Ports:
- clk  in  1  main clock; every register is clocked by it.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  0 forces PRIME and flushes the buffer.
- rpi_clk  in  1  Pi shift clock (asynchronous); sampled internally.
- serial  in  1  Pi serial data; valid on rpi_clk rising edge.
- ready  in  1  I2S request; synchronous to clk; a rising edge is one request.
- rpi_interrupt  out  1  request more words from the Pi.
- data  out  16  current output sample.
- level  out  7  buffer occupancy, 0..64.
- underrun  out  1  sticky; cleared by enable=0.
- overflow  out  1  sticky; cleared by enable=0.
- debug  out  10  {state[1:0], level[6:0], bit_cnt[3]}.

Behaviour:
- Reset (rst_n low, any time): all outputs 0; state=PRIME; rd_ptr=wr_ptr=0; count=0; bit_cnt=0; shift register 0. Buffer RAM contents are don't-care.
- rpi_clk input path:
  - Passes through a 2-FF synchroniser, then a third register for edge detection.
  - Edge pulse occurs 3 clk after the rpi_clk rise.
  - serial is delayed by the same 3 stages so it stays aligned with the edge pulse.
  - rpi_clk must be below clk/4.
- Deserialiser:
  - On each edge pulse, shift[bit_cnt] <= serial (LSB first); bit_cnt increments and wraps 15->0.
  - When bit_cnt==15, the completed word (including the current bit) is written next cycle.
  - Write when count<DEPTH: mem[wr_ptr] <= word; wr_ptr+1 (wraps mod DEPTH); count+1.
  - Write when count==DEPTH: word is dropped, overflow<=1, pointers unchanged.
- Ready edge: ready registered once; request = ready & ~ready_q.
- States:
  - PRIME: data=0. On a request: pointers unchanged, no underrun. Transition to RUN when count>=START_LEVEL and enable=1.
  - RUN, request with count>0: data <= mem[rd_ptr] on the cycle after the request (1-cycle latency); rd_ptr+1 (wraps); count-1.
  - RUN, request with count==0: data <= 0; underrun<=1; state -> PRIME.
  - enable=0 (any state): state=PRIME; pointers, count and bit_cnt cleared; underrun and overflow cleared; data=0; rpi_interrupt=0.
- Simultaneous write and read in one cycle: both performed; count unchanged. A read of an entry written in the same cycle is not possible, because count>0 is checked before the write.
- rpi_interrupt (registered, only while enable=1):
  - Sets when count<=LOW_WATER.
  - Clears when count>=HIGH_WATER.
  - Otherwise holds; between the thresholds it keeps its previous value.
  - In PRIME, asserted whenever count<START_LEVEL.
- level mirrors count (registered).
- Arithmetic: pointers log2(DEPTH) bits, wrapping naturally; count log2(DEPTH)+1 bits, never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset then enable=1, shift 32 words 0x0001..0x0020 LSB-first -> level=32, state RUN, rpi_interrupt stays 1 until level>=48.
- In RUN, pulse ready 3 times -> data=0x0001, 0x0002, 0x0003, each one cycle after the request; level 32->29.
- Fill to 64, shift one more word 0xBEEF -> overflow=1, level=64, 0xBEEF never appears on data.
- Drain to 0, pulse ready -> data=0x0000, underrun=1, state PRIME; further ready pulses leave level 0; refill to 32 -> RUN.
- Watermark hysteresis: from 48, drain to 17 -> rpi_interrupt=0; at 16 -> 1; refill to 47 -> still 1; at 48 -> 0.
- Assert rst_n low mid-word (bit_cnt=7) with level=20 -> all outputs 0 immediately (asynchronous); next word after release is aligned from bit 0.
